// File: rtl/controller_pkg.sv
// Shared definitions for the instruction-cycle controller: opcode and phase
// encodings, the bundled control-word type and the ALU-opcode classifier.
package controller_pkg;

    // Opcode encodings
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Instruction-cycle phase encodings
    localparam logic [2:0] PHASE_INST_ADDR  = 3'd0;
    localparam logic [2:0] PHASE_INST_FETCH = 3'd1;
    localparam logic [2:0] PHASE_INST_LOAD  = 3'd2;
    localparam logic [2:0] PHASE_IDLE       = 3'd3;
    localparam logic [2:0] PHASE_OP_ADDR    = 3'd4;
    localparam logic [2:0] PHASE_OP_FETCH   = 3'd5;
    localparam logic [2:0] PHASE_ALU_OP     = 3'd6;
    localparam logic [2:0] PHASE_STORE      = 3'd7;

    // All nine control strobes, MSB first in the order they are usually listed
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic halt;
        logic ld_pc;
        logic data_e;
        logic ld_ac;
        logic wr;
    } ctrl_t;

    // Opcodes that read an operand from memory and load the accumulator
    function automatic logic is_alu_op(input logic [2:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
    endfunction

endpackage

// File: rtl/controller_if.sv
// Control bus between the sequencer (master: drives opcode/phase/zero) and
// the controller (slave: returns the nine control strobes).
interface controller_if;

    logic [2:0] opcode;
    logic [2:0] phase;
    logic       zero;

    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;

    modport master (
        output opcode, phase, zero,
        input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

    modport slave (
        input  opcode, phase, zero,
        output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

endinterface

// File: rtl/controller.sv
// Instruction-cycle controller: decodes phase/opcode/zero into the CPU
// control strobes with zero-cycle latency.
// Optional feature: define CONTROLLER_HALT_HOLD_EN to make halt sticky
// (held until rst); without it the block is purely combinational.
module controller
    import controller_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    controller_if.slave  bus
);

    ctrl_t dec;
    ctrl_t ctrl;
    logic  alu_op;

    assign alu_op = is_alu_op(bus.opcode);

    // Phase-by-phase decode of the control word; everything defaults low
    always_comb begin
        dec = '0;
        case (bus.phase)
            PHASE_INST_ADDR: begin
                dec.sel = 1'b1;
            end
            PHASE_INST_FETCH: begin
                dec.sel = 1'b1;
                dec.rd  = 1'b1;
            end
            PHASE_INST_LOAD, PHASE_IDLE: begin
                dec.sel   = 1'b1;
                dec.rd    = 1'b1;
                dec.ld_ir = 1'b1;
            end
            PHASE_OP_ADDR: begin
                dec.inc_pc = 1'b1;
                dec.halt   = (bus.opcode == OP_HLT);
            end
            PHASE_OP_FETCH: begin
                dec.rd = alu_op;
            end
            PHASE_ALU_OP: begin
                dec.rd     = alu_op;
                dec.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                dec.ld_pc  = (bus.opcode == OP_JMP);
                dec.data_e = (bus.opcode == OP_STO);
            end
            PHASE_STORE: begin
                dec.rd     = alu_op;
                dec.ld_ac  = alu_op;
                dec.ld_pc  = (bus.opcode == OP_JMP);
                dec.data_e = (bus.opcode == OP_STO);
                dec.wr     = (bus.opcode == OP_STO);
            end
            default: begin
                dec = '0;
            end
        endcase
    end

`ifdef CONTROLLER_HALT_HOLD_EN
    logic halted;

    // Latch a halt request so the machine stays stopped until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (ctrl.halt) begin
            halted <= 1'b1;
        end
    end

    // While halted, only the halt strobe stays asserted
    always_comb begin
        ctrl = dec;
        if (halted) begin
            ctrl      = '0;
            ctrl.halt = 1'b1;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;

    // No sticky halt: the decoded word goes straight out
    always_comb begin
        ctrl = dec;
    end
`endif

    assign bus.sel    = ctrl.sel;
    assign bus.rd     = ctrl.rd;
    assign bus.ld_ir  = ctrl.ld_ir;
    assign bus.inc_pc = ctrl.inc_pc;
    assign bus.halt   = ctrl.halt;
    assign bus.ld_pc  = ctrl.ld_pc;
    assign bus.data_e = ctrl.data_e;
    assign bus.ld_ac  = ctrl.ld_ac;
    assign bus.wr     = ctrl.wr;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: a table of known control words,
// randomized stimulus against a per-output rule model, and a hand-written
// halt/reset sequence (sticky in CONTROLLER_HALT_HOLD_EN builds).
module tb_controller;

    typedef struct {
        logic [2:0] opcode;
        logic [2:0] phase;
        logic       zero;
        logic [8:0] expected;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    bit   model_halted;
    vec_t vectors[$];

    controller_if bus();

    controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [8:0] dut_word;
    assign dut_word = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
                       bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rule model: each strobe written as its own condition over phase/opcode
    function automatic logic [8:0] model_word(input logic [2:0] opc,
                                              input logic [2:0] ph,
                                              input logic z,
                                              input bit halted_state);
        bit alu;
        bit s, r, li, ip, h, lp, de, la, w;
        int p;
        int o;
        p   = int'(ph);
        o   = int'(opc);
        alu = (o >= 2) && (o <= 5);
        s   = (p <= 3);
        r   = (p >= 1 && p <= 3) || (alu && p >= 5);
        li  = (p == 2) || (p == 3);
        ip  = (p == 4) || (p == 6 && o == 1 && z);
        h   = (p == 4) && (o == 0);
        lp  = (o == 7) && (p >= 6);
        de  = (o == 6) && (p >= 6);
        la  = alu && (p == 7);
        w   = (o == 6) && (p == 7);
        if (halted_state) return 9'b000010000;
        return {s, r, li, ip, h, lp, de, la, w};
    endfunction

`ifdef CONTROLLER_HALT_HOLD_EN
    // Track the sticky-halt state the way the rules describe it
    always @(posedge clk) begin
        if (rst) model_halted <= 1'b0;
        else if (model_word(bus.opcode, bus.phase, bus.zero, model_halted) & 9'b000010000)
            model_halted <= 1'b1;
    end
`endif

    function automatic void addVec(input logic [2:0] opc, input logic [2:0] ph,
                                   input logic z, input logic [8:0] exp_w,
                                   input string name);
        vec_t v;
        v.opcode   = opc;
        v.phase    = ph;
        v.zero     = z;
        v.expected = exp_w;
        v.name     = name;
        vectors.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [2:0] opc, input logic [2:0] ph,
                                 input logic z);
        @(negedge clk);
        bus.opcode = opc;
        bus.phase  = ph;
        bus.zero   = z;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] exp_w);
        checks++;
        if (dut_word !== exp_w) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, dut_word, exp_w);
        end
    endtask

    initial begin
        logic [2:0] opc;
        logic [2:0] ph;
        logic       z;
        errors       = 0;
        checks       = 0;
        model_halted = 1'b0;
        rst          = 1'b1;
        bus.opcode   = 3'd0;
        bus.phase    = 3'd0;
        bus.zero     = 1'b0;

        addVec(3'd0, 3'd0, 1'b0, 9'b100000000, "hlt_p0");
        addVec(3'd0, 3'd1, 1'b0, 9'b110000000, "hlt_p1");
        addVec(3'd0, 3'd2, 1'b0, 9'b111000000, "hlt_p2");
        addVec(3'd0, 3'd3, 1'b0, 9'b111000000, "hlt_p3");
        addVec(3'd0, 3'd4, 1'b0, 9'b000110000, "hlt_p4");
        addVec(3'd0, 3'd5, 1'b0, 9'b000000000, "hlt_p5");
        addVec(3'd0, 3'd6, 1'b0, 9'b000000000, "hlt_p6");
        addVec(3'd0, 3'd7, 1'b0, 9'b000000000, "hlt_p7");
        addVec(3'd1, 3'd6, 1'b0, 9'b000000000, "skz_p6_z0");
        addVec(3'd1, 3'd6, 1'b1, 9'b000100000, "skz_p6_z1");
        addVec(3'd1, 3'd7, 1'b1, 9'b000000000, "skz_p7_z1");
        for (int a = 2; a <= 5; a++) begin
            addVec(3'(a), 3'd4, 1'b0, 9'b000100000, $sformatf("alu%0d_p4", a));
            addVec(3'(a), 3'd5, 1'b0, 9'b010000000, $sformatf("alu%0d_p5", a));
            addVec(3'(a), 3'd6, 1'b1, 9'b010000000, $sformatf("alu%0d_p6", a));
            addVec(3'(a), 3'd7, 1'b0, 9'b010000010, $sformatf("alu%0d_p7", a));
        end
        addVec(3'd6, 3'd5, 1'b0, 9'b000000000, "sto_p5");
        addVec(3'd6, 3'd6, 1'b1, 9'b000000100, "sto_p6");
        addVec(3'd6, 3'd7, 1'b0, 9'b000000101, "sto_p7");
        addVec(3'd7, 3'd5, 1'b0, 9'b000000000, "jmp_p5");
        addVec(3'd7, 3'd6, 1'b0, 9'b000001000, "jmp_p6");
        addVec(3'd7, 3'd7, 1'b1, 9'b000001000, "jmp_p7");

        // Known control words, rst held high so no halt can stick
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].opcode, vectors[i].phase, vectors[i].zero);
            checkOutput(vectors[i].name, vectors[i].expected);
        end

        // Random inputs against the rule model
        for (int n = 0; n < 300; n++) begin
            opc = 3'($urandom_range(0, 7));
            ph  = 3'($urandom_range(0, 7));
            z   = 1'($urandom_range(0, 1));
            applyStimulus(opc, ph, z);
            checkOutput($sformatf("rand%0d_op%0d_ph%0d_z%0d", n, opc, ph, z),
                        model_word(opc, ph, z, model_halted));
        end

        // Halt request crossing a clock edge, then a reset pulse
        rst = 1'b0;
        applyStimulus(3'd0, 3'd4, 1'b0);
        checkOutput("seq_hlt_p4", 9'b000110000);
        applyStimulus(3'd0, 3'd0, 1'b0);
`ifdef CONTROLLER_HALT_HOLD_EN
        checkOutput("seq_after_halt_p0", 9'b000010000);
        applyStimulus(3'd2, 3'd7, 1'b1);
        checkOutput("seq_halted_alu_p7", 9'b000010000);
`else
        checkOutput("seq_after_halt_p0", 9'b100000000);
        applyStimulus(3'd2, 3'd7, 1'b1);
        checkOutput("seq_no_hold_alu_p7", 9'b010000010);
`endif
        rst = 1'b1;
        applyStimulus(3'd0, 3'd0, 1'b0);
        rst = 1'b0;
        checkOutput("seq_after_rst_p0", 9'b100000000);
        applyStimulus(3'd6, 3'd7, 1'b0);
        checkOutput("seq_after_rst_sto_p7", 9'b000000101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
